// File: rtl/sme_pkg.sv
// Shared constants, FSM state type and case-folding helpers for the
// parametrised string-matching engine.
package sme_pkg;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_S = 3'd1,
    LOAD_P = 3'd2,
    SEARCH = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic [7:0] fold(input logic [7:0] c, input logic en);
    if (en && (c >= 8'h41) && (c <= 8'h5A)) begin
      return c | 8'h20;
    end else begin
      return c;
    end
  endfunction

  function automatic logic fold_eq(input logic [7:0] a, input logic [7:0] b,
                                   input logic nocase);
    return fold(a, nocase) == fold(b, nocase);
  endfunction

endpackage

// File: rtl/sme_char_cmp.sv
// Combinational compare of one pattern character against one string character,
// honouring the '.' wildcard and ASCII case folding.
module sme_char_cmp
  import sme_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] pch,
  input  logic [CW-1:0] sch,
  input  logic          nocase,
  output logic          eq
);

  logic w_hi_eq;

  // bits above the ASCII byte must match exactly; only the low byte is folded
  always_comb begin
    w_hi_eq = ((pch >> 4'd8) == (sch >> 4'd8));
    eq      = (pch == CW'(CH_DOT)) || (w_hi_eq && fold_eq(pch[7:0], sch[7:0], nocase));
  end

endmodule

// File: rtl/sme_param_engine.sv
// String-matching engine: serial string/pattern load, then a candidate-by-candidate
// search reporting first match index, match count and buffer overflow.
module sme_param_engine
  import sme_pkg::*;
#(
  parameter int CW      = 8,
  parameter int MAX_STR = 32,
  parameter int MAX_PAT = 8,
  parameter int IW      = $clog2(MAX_STR),
  parameter int NW      = $clog2(MAX_STR + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] chardata,
  input  logic          isstring,
  input  logic          ispattern,
  input  logic          nocase,
  output logic          busy,
  output logic          valid,
  output logic          match,
  output logic [IW-1:0] match_index,
  output logic [NW-1:0] match_count,
  output logic          err
);

  localparam int KW  = $clog2(MAX_PAT + 1);
  localparam int PIW = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;
  localparam logic [NW-1:0] ONE_N  = NW'(1);
  localparam logic [NW-1:0] ZERO_N = {NW{1'b0}};
  localparam logic [KW-1:0] ONE_K  = KW'(1);
  localparam logic [KW-1:0] ZERO_K = {KW{1'b0}};
  localparam logic [NW-1:0] SAT_N  = NW'(MAX_STR);

  logic [CW-1:0] r_str [MAX_STR];
  logic [CW-1:0] r_pat [MAX_PAT];
  state_t        r_state;
  logic [NW-1:0] r_slen, r_s, r_pos, r_suf_max, r_cnt;
  logic [KW-1:0] r_plen, r_k, r_star_idx;
  logic [IW-1:0] r_idx;
  logic          r_has_star, r_nocase, r_scan, r_suf_ok, r_ovf, r_found;
  logic          r_busy, r_valid, r_match, r_err;
  logic [IW-1:0] r_match_index;
  logic [NW-1:0] r_match_count;

  logic [CW-1:0] w_pch, w_sch, w_sprev;
  logic [NW-1:0] w_pm1, w_cnt_n;
  logic [KW-1:0] w_end;
  logic [IW-1:0] w_idx_n;
  logic          w_eq, w_ok, w_consume, w_run_done, w_hit, w_advance, w_last, w_found_n;

  sme_char_cmp #(.CW(CW)) u_cmp (
    .pch    (w_pch),
    .sch    (w_sch),
    .nocase (r_nocase),
    .eq     (w_eq)
  );

  // Element evaluation. r_scan first finds the last suffix start that matches
  // after the honoured '*', so each candidate only has to run its prefix.
  always_comb begin
    w_end      = (r_has_star && !r_scan) ? r_star_idx : r_plen;
    w_run_done = (r_k == w_end);
    w_pch      = r_pat[r_k[PIW-1:0]];
    w_sch      = r_str[r_pos[IW-1:0]];
    w_pm1      = r_pos - ONE_N;
    w_sprev    = r_str[w_pm1[IW-1:0]];
    w_consume  = 1'b0;
    if (w_pch == CW'(CH_CARET)) begin
      w_ok = (r_pos == ZERO_N) || (w_sprev == CW'(CH_SPACE));
    end else if (w_pch == CW'(CH_DOLLAR)) begin
      w_ok = (r_pos == r_slen) || (w_sch == CW'(CH_SPACE));
    end else begin
      w_ok      = (r_pos < r_slen) && w_eq;
      w_consume = 1'b1;
    end
    w_hit     = !r_scan && w_run_done &&
                (!r_has_star || (r_suf_ok && (r_pos <= r_suf_max)));
    w_advance = w_run_done || !w_ok;
    w_last    = (r_s == r_slen);
    w_found_n = r_found | w_hit;
    w_idx_n   = (w_hit && !r_found) ? r_s[IW-1:0] : r_idx;
    w_cnt_n   = (w_hit && (r_cnt != SAT_N)) ? (r_cnt + ONE_N) : r_cnt;
  end

  // Load/search FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_slen        <= ZERO_N;
      r_plen        <= ZERO_K;
      r_s           <= ZERO_N;
      r_pos         <= ZERO_N;
      r_k           <= ZERO_K;
      r_star_idx    <= ZERO_K;
      r_suf_max     <= ZERO_N;
      r_cnt         <= ZERO_N;
      r_idx         <= {IW{1'b0}};
      r_has_star    <= 1'b0;
      r_nocase      <= 1'b0;
      r_scan        <= 1'b0;
      r_suf_ok      <= 1'b0;
      r_ovf         <= 1'b0;
      r_found       <= 1'b0;
      r_busy        <= 1'b0;
      r_valid       <= 1'b0;
      r_match       <= 1'b0;
      r_err         <= 1'b0;
      r_match_index <= {IW{1'b0}};
      r_match_count <= ZERO_N;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (isstring) begin
            r_str[0] <= chardata;
            r_slen   <= ONE_N;
            r_ovf    <= 1'b0;
            r_state  <= LOAD_S;
          end else if (ispattern) begin
            r_pat[0]   <= chardata;
            r_plen     <= ONE_K;
            r_nocase   <= nocase;
            r_has_star <= (chardata == CW'(CH_STAR));
            r_star_idx <= ZERO_K;
            r_ovf      <= 1'b0;
            r_state    <= LOAD_P;
          end else begin
            r_state <= IDLE;
          end
        end
        LOAD_S: begin
          if (isstring) begin
            if (r_slen < SAT_N) begin
              r_str[r_slen[IW-1:0]] <= chardata;
              r_slen                <= r_slen + ONE_N;
            end else begin
              r_ovf <= 1'b1;
            end
          end else if (ispattern) begin
            r_pat[0]   <= chardata;
            r_plen     <= ONE_K;
            r_nocase   <= nocase;
            r_has_star <= (chardata == CW'(CH_STAR));
            r_star_idx <= ZERO_K;
            r_state    <= LOAD_P;
          end else begin
            r_state <= IDLE;
          end
        end
        LOAD_P: begin
          if (ispattern && !isstring) begin
            if (r_plen < KW'(MAX_PAT)) begin
              r_pat[r_plen[PIW-1:0]] <= chardata;
              r_plen                 <= r_plen + ONE_K;
              if ((chardata == CW'(CH_STAR)) && !r_has_star) begin
                r_has_star <= 1'b1;
                r_star_idx <= r_plen;
              end
            end else begin
              r_ovf <= 1'b1;
            end
          end else begin
            r_state   <= SEARCH;
            r_busy    <= 1'b1;
            r_scan    <= r_has_star;
            r_s       <= ZERO_N;
            r_pos     <= ZERO_N;
            r_k       <= r_has_star ? (r_star_idx + ONE_K) : ZERO_K;
            r_suf_ok  <= 1'b0;
            r_suf_max <= ZERO_N;
            r_found   <= 1'b0;
            r_idx     <= {IW{1'b0}};
            r_cnt     <= ZERO_N;
          end
        end
        SEARCH: begin
          if (w_advance) begin
            if (r_scan && w_run_done) begin
              r_suf_ok  <= 1'b1;
              r_suf_max <= r_s;
            end
            r_found <= w_found_n;
            r_idx   <= w_idx_n;
            r_cnt   <= w_cnt_n;
            if (w_last && r_scan) begin
              r_scan <= 1'b0;
              r_s    <= ZERO_N;
              r_pos  <= ZERO_N;
              r_k    <= ZERO_K;
            end else if (w_last) begin
              r_state       <= DONE;
              r_busy        <= 1'b0;
              r_valid       <= 1'b1;
              r_match       <= w_found_n;
              r_match_index <= w_idx_n;
              r_match_count <= w_cnt_n;
              r_err         <= r_ovf;
            end else begin
              r_s   <= r_s + ONE_N;
              r_pos <= r_s + ONE_N;
              r_k   <= r_scan ? (r_star_idx + ONE_K) : ZERO_K;
            end
          end else begin
            r_k <= r_k + ONE_K;
            if (w_consume) begin
              r_pos <= r_pos + ONE_N;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign valid       = r_valid;
  assign match       = r_match;
  assign match_index = r_match_index;
  assign match_count = r_match_count;
  assign err         = r_err;

endmodule

// File: tb/tb_sme_param_engine.sv
// Bench for sme_param_engine: directed scenarios plus random strings/patterns,
// each result compared against a rule-level reference matcher.
module tb_sme_param_engine;

  localparam int CW = 8, MAX_STR = 32, MAX_PAT = 8, IW = 5, NW = 6;
  localparam int BOUND = (MAX_STR + 1) * (MAX_STR + MAX_PAT + 1) + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] chardata = 8'h00;
  logic          isstring = 1'b0, ispattern = 1'b0, nocase = 1'b0;
  logic          busy, valid, match, err;
  logic [IW-1:0] match_index;
  logic [NW-1:0] match_count;

  sme_param_engine #(.CW(CW), .MAX_STR(MAX_STR), .MAX_PAT(MAX_PAT), .IW(IW), .NW(NW)) dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .nocase(nocase), .busy(busy), .valid(valid),
    .match(match), .match_index(match_index), .match_count(match_count), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  byte unsigned m_str[$];
  byte unsigned m_pat[$];
  bit m_nc = 1'b0;
  bit m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic byte unsigned lc(input byte unsigned c);
    return (m_nc && c >= 8'h41 && c <= 8'h5A) ? c + 8'd32 : c;
  endfunction

  // end position of pattern elements k0..k1-1 placed at p, or -1
  function automatic int run(input int p, input int k0, input int k1);
    int q;
    q = p;
    for (int k = k0; k < k1; k++) begin
      byte unsigned c;
      c = m_pat[k];
      if (c == 8'h5E) begin
        if (!(q == 0 || m_str[q-1] == 8'h20)) return -1;
      end else if (c == 8'h24) begin
        if (!(q == m_str.size() || m_str[q] == 8'h20)) return -1;
      end else begin
        if (q >= m_str.size()) return -1;
        if (c != 8'h2E && lc(c) != lc(m_str[q])) return -1;
        q++;
      end
    end
    return q;
  endfunction

  task automatic model(output bit f, output int idx, output int cnt);
    int ks, e;
    bit ok;
    ks = -1;
    for (int k = 0; k < m_pat.size(); k++)
      if (m_pat[k] == 8'h2A && ks < 0) ks = k;
    f = 0; idx = 0; cnt = 0;
    for (int s = 0; s <= m_str.size(); s++) begin
      if (ks < 0) begin
        ok = (run(s, 0, m_pat.size()) >= 0);
      end else begin
        ok = 0;
        e = run(s, 0, ks);
        if (e >= 0)
          for (int j = e; j <= m_str.size(); j++)
            if (run(j, ks + 1, m_pat.size()) >= 0) ok = 1;
      end
      if (ok) begin
        if (!f) begin f = 1; idx = s % MAX_STR; end
        if (cnt < MAX_STR) cnt++;
      end
    end
  endtask

  task automatic load_str(input string s);
    m_str.delete();
    m_ovf = 0;
    for (int i = 0; i < s.len(); i++) begin
      chardata = s[i];
      isstring = 1'b1;
      if (m_str.size() < MAX_STR) m_str.push_back(s[i]);
      else m_ovf = 1;
      tick();
    end
    isstring = 1'b0;
  endtask

  // cont=1 when the pattern directly follows a string load
  task automatic load_pat(input string p, input bit nc, input bit cont);
    if (!cont) m_ovf = 0;
    m_pat.delete();
    m_nc = nc;
    for (int i = 0; i < p.len(); i++) begin
      chardata  = p[i];
      ispattern = 1'b1;
      nocase    = (i == 0) ? nc : !nc;
      if (m_pat.size() < MAX_PAT) m_pat.push_back(p[i]);
      else m_ovf = 1;
      tick();
    end
    ispattern = 1'b0;
    nocase    = 1'b0;
  endtask

  task automatic run_case(input string tag, input bit poke);
    bit ef;
    int ei, ec, n;
    model(ef, ei, ec);
    tick();
    check($sformatf("%s_busy_rise", tag), 32'(busy), 32'd1);
    n = 0;
    if (poke) begin
      chardata = 8'h7A;
      isstring = 1'b1;
      tick();
      isstring = 1'b0;
      n = 1;
    end
    while (valid !== 1'b1 && n < BOUND + 10) begin
      tick();
      n++;
    end
    check($sformatf("%s_latency_ok", tag), 32'(n <= BOUND), 32'd1);
    check($sformatf("%s_valid", tag), 32'(valid), 32'd1);
    check($sformatf("%s_busy_fall", tag), 32'(busy), 32'd0);
    check($sformatf("%s_match", tag), 32'(match), 32'(ef));
    check($sformatf("%s_idx", tag), 32'(match_index), 32'(ei));
    check($sformatf("%s_cnt", tag), 32'(match_count), 32'(ec));
    check($sformatf("%s_err", tag), 32'(err), 32'(m_ovf));
    tick();
    check($sformatf("%s_valid_drop", tag), 32'(valid), 32'd0);
    check($sformatf("%s_match_hold", tag), 32'(match), 32'(ef));
  endtask

  string alpha_s = "abAB ";
  string alpha_p = "ab.^$*A ";

  initial begin
    string s, p;
    bit seen;

    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_idx", 32'(match_index), 32'd0);
    check("rst_cnt", 32'(match_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick();

    load_pat("^$", 0, 0);   run_case("empty_anchor", 0);
    check("empty_anchor_c", 32'(match), 32'd1);
    load_pat("a", 0, 0);    run_case("empty_lit", 0);
    check("empty_lit_c", 32'(match), 32'd0);

    load_str("hello world"); load_pat("wor", 0, 1); run_case("t1", 1);
    check("t1_idx_c", 32'(match_index), 32'd6);
    check("t1_cnt_c", 32'(match_count), 32'd1);
    load_pat("^w.r", 0, 0); run_case("t2a", 0);
    check("t2a_idx_c", 32'(match_index), 32'd6);
    load_pat("o$", 0, 0);   run_case("t2b", 0);

    load_str("ab ab"); load_pat("ab$", 0, 1); run_case("t3a", 0);
    check("t3a_cnt_c", 32'(match_count), 32'd2);
    load_pat("a*b", 0, 0);  run_case("t3b", 0);
    check("t3b_cnt_c", 32'(match_count), 32'd2);

    load_str("HeLLo"); load_pat("hel", 1, 1); run_case("t4a", 0);
    check("t4a_match_c", 32'(match), 32'd1);
    load_pat("hel", 0, 0);  run_case("t4b", 0);
    check("t4b_match_c", 32'(match), 32'd0);

    s = "";
    for (int i = 0; i < MAX_STR - 1; i++) s = $sformatf("%sa", s);
    s = $sformatf("%sbcde", s);
    load_str(s); load_pat("x", 0, 1); run_case("t5a", 0);
    check("t5a_err_c", 32'(err), 32'd1);
    load_pat("b$", 0, 0);   run_case("t5b", 0);
    check("t5b_idx_c", 32'(match_index), 32'(MAX_STR - 1));
    check("t5b_err_c", 32'(err), 32'd0);

    s = "";
    for (int i = 0; i < MAX_STR; i++) s = $sformatf("%sa", s);
    load_str(s); load_pat("*", 0, 1); run_case("sat", 0);
    check("sat_cnt_c", 32'(match_count), 32'(MAX_STR));
    load_pat("aaaaaaaaaa", 0, 0); run_case("pat_ovf", 0);

    load_str("hello world"); load_pat("wor", 0, 1);
    tick(); tick();
    check("t6_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_str.delete();
    m_ovf = 0;
    check("t6_busy0", 32'(busy), 32'd0);
    check("t6_match0", 32'(match), 32'd0);
    check("t6_idx0", 32'(match_index), 32'd0);
    check("t6_cnt0", 32'(match_count), 32'd0);
    check("t6_err0", 32'(err), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid === 1'b1) seen = 1;
    end
    check("t6_no_valid", 32'(seen), 32'd0);
    load_str("xyz world"); load_pat("wo", 0, 1); run_case("t6_after", 0);

    for (int it = 0; it < 40; it++) begin
      bit fresh;
      fresh = (it == 0) || ($urandom_range(0, 3) != 0);
      if (fresh) begin
        s = "";
        for (int i = 0; i < $urandom_range(1, MAX_STR + 2); i++)
          s = $sformatf("%s%c", s, alpha_s[$urandom_range(0, 4)]);
        load_str(s);
      end
      p = "";
      for (int i = 0; i < $urandom_range(1, MAX_PAT + 1); i++)
        p = $sformatf("%s%c", p, alpha_p[$urandom_range(0, 7)]);
      load_pat(p, 1'($urandom_range(0, 1)), fresh);
      run_case($sformatf("rnd%0d", it), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
